// File: rtl/ws2812_pkg.sv
// Shared types and helpers for the multi-channel WS2812 serializer.
package ws2812_pkg;

   typedef enum logic [1:0] {IDLE, FETCH, SEND, GAP} state_t;

   localparam int PIXEL_W = 24;
   localparam int MAX_CH  = 32;

   // Channel c's GRB slice of a (zero-extended) pixel word.
   function automatic logic [PIXEL_W-1:0] chan_slice(input logic [MAX_CH*PIXEL_W-1:0] word,
                                                     input int c);
      return word[c*PIXEL_W +: PIXEL_W];
   endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Shared bit-period timer: cycle position within a bit and bit index within a pixel.
module ws2812_bit_timer
   import ws2812_pkg::*;
#(
   parameter int T_BIT = 125,
   parameter int T0H   = 40,
   parameter int T1H   = 80,
   localparam int CW   = $clog2(T_BIT)
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic run,
   output logic bit_start,
   output logic bit_end,
   output logic last_bit,
   output logic hi0,
   output logic hi1
);

   logic [CW-1:0] cyc_cnt;
   logic [4:0]    bit_cnt;

   // Idle counters park at the start of bit 23 so SEND can begin without a setup cycle.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cyc_cnt <= '0;
         bit_cnt <= 5'(PIXEL_W-1);
      end else if (!run) begin
         cyc_cnt <= '0;
         bit_cnt <= 5'(PIXEL_W-1);
      end else if (bit_end) begin
         cyc_cnt <= '0;
         bit_cnt <= (bit_cnt == 5'd0) ? 5'(PIXEL_W-1) : bit_cnt - 5'd1;
      end else begin
         cyc_cnt <= cyc_cnt + CW'(1);
      end
   end

   assign bit_start = (cyc_cnt == '0);
   assign bit_end   = (cyc_cnt == CW'(T_BIT-1));
   assign last_bit  = (bit_cnt == 5'd0);
   assign hi0       = (cyc_cnt < CW'(T0H));
   assign hi1       = (cyc_cnt < CW'(T1H));

endmodule

// File: rtl/ws2812_multi_out.sv
// N-channel WS2812 serializer: fetches one pixel word per LED and drives all lines in parallel.
//  state | meaning
//  IDLE  | waiting for frame_rdy_in or a pending request
//  FETCH | first pixel read in flight
//  SEND  | shifting bits out, prefetching the next pixel during bit 0
//  GAP   | lines low for the latch gap, then done_out
module ws2812_multi_out
   import ws2812_pkg::*;
#(
   parameter int NUM_CH   = 8,
   parameter int MAX_LEDS = 64,
   parameter int T_BIT    = 125,
   parameter int T0H      = 40,
   parameter int T1H      = 80,
   parameter int T_RST    = 30000,
   localparam int LW      = $clog2(MAX_LEDS+1),
   localparam int AW      = (MAX_LEDS > 1) ? $clog2(MAX_LEDS) : 1
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      frame_rdy_in,
   input  logic [LW-1:0]             led_num_in,
   input  logic [NUM_CH-1:0]         chan_en_in,
   output logic                      rd_en_out,
   output logic [AW-1:0]             rd_addr_out,
   input  logic [NUM_CH*PIXEL_W-1:0] rd_data_in,
   output logic                      busy_out,
   output logic                      done_out,
   output logic [NUM_CH-1:0]         ws2812_data_out
);

   localparam int PW = NUM_CH*PIXEL_W;
   localparam int XW = MAX_CH*PIXEL_W;
   localparam int GW = $clog2(T_RST+1);

   if (!(T0H < T1H && T1H < T_BIT)) begin : g_bad_timing
      $fatal(1, "ws2812_multi_out: T0H < T1H < T_BIT violated");
   end
   if (T_RST < T_BIT) begin : g_bad_gap
      $fatal(1, "ws2812_multi_out: T_RST must be >= T_BIT");
   end
   if (MAX_LEDS < 1 || NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_size
      $fatal(1, "ws2812_multi_out: MAX_LEDS >= 1 and 1 <= NUM_CH <= 32 required");
   end

   state_t          state, state_nxt;
   logic [LW-1:0]   led_num_q, led_idx, led_num_sat;
   logic [NUM_CH-1:0] chan_en_q, line_nxt;
   logic [PW-1:0]   shift_q, next_pix_q;
   logic [XW-1:0]   shift_ext;
   logic [GW-1:0]   gap_cnt;
   logic            rd_en_d1, pending_q;
   logic            start, more_leds, led_end, gap_done, send;
   logic            bit_start, bit_end, last_bit, hi0, hi1;

   assign send        = (state == SEND);
   assign start       = frame_rdy_in | pending_q;
   assign led_num_sat = (led_num_in > LW'(MAX_LEDS)) ? LW'(MAX_LEDS) : led_num_in;
   assign more_leds   = (led_idx + LW'(1)) < led_num_q;
   assign led_end     = bit_end & last_bit;
   assign gap_done    = (gap_cnt == '0);

   ws2812_bit_timer #(.T_BIT(T_BIT), .T0H(T0H), .T1H(T1H)) u_timer (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .run       (send),
      .bit_start (bit_start),
      .bit_end   (bit_end),
      .last_bit  (last_bit),
      .hi0       (hi0),
      .hi1       (hi1)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (led_num_sat == '0) ? GAP : FETCH;
         FETCH:   if (rd_en_d1) state_nxt = SEND;
         SEND:    if (led_end && !more_leds) state_nxt = GAP;
         GAP:     if (gap_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rd_en_out   <= 1'b0;
         rd_addr_out <= '0;
         rd_en_d1    <= 1'b0;
         busy_out    <= 1'b0;
         done_out    <= 1'b0;
         pending_q   <= 1'b0;
         led_num_q   <= '0;
         led_idx     <= '0;
         chan_en_q   <= '0;
         shift_q     <= '0;
         next_pix_q  <= '0;
         gap_cnt     <= '0;
      end else begin
         rd_en_out <= 1'b0;
         rd_en_d1  <= rd_en_out;
         done_out  <= 1'b0;
         if (state != IDLE && frame_rdy_in) pending_q <= 1'b1;
         case (state)
            IDLE: if (start) begin
               led_num_q <= led_num_sat;
               chan_en_q <= chan_en_in;
               pending_q <= 1'b0;
               busy_out  <= 1'b1;
               led_idx   <= '0;
               if (led_num_sat == '0) begin
                  gap_cnt <= GW'(T_RST-1);
               end else begin
                  rd_en_out   <= 1'b1;
                  rd_addr_out <= '0;
               end
            end
            FETCH: if (rd_en_d1) shift_q <= rd_data_in;
            SEND: begin
               if (bit_start && last_bit && more_leds) begin
                  rd_en_out   <= 1'b1;
                  rd_addr_out <= AW'(led_idx + LW'(1));
               end
               if (rd_en_d1) next_pix_q <= rd_data_in;
               // Whole-word shift: bits leaking across channel boundaries only reach
               // a channel's LSB end and are never read before the next reload.
               if (led_end) begin
                  if (more_leds) begin
                     shift_q <= rd_en_d1 ? rd_data_in : next_pix_q;
                     led_idx <= led_idx + LW'(1);
                  end else begin
                     // One extra count covers the last bit's tail still in the output register.
                     gap_cnt <= GW'(T_RST);
                  end
               end else if (bit_end) begin
                  shift_q <= shift_q << 1;
               end
            end
            GAP: begin
               if (gap_done) begin
                  done_out <= 1'b1;
                  busy_out <= pending_q | frame_rdy_in;
               end else begin
                  gap_cnt <= gap_cnt - GW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign shift_ext = XW'(shift_q);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [PIXEL_W-1:0] slice;
      assign slice       = chan_slice(shift_ext, c);
      assign line_nxt[c] = send & (slice[PIXEL_W-1] ? hi1 : hi0) & chan_en_q[c];
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) ws2812_data_out <= '0;
      else        ws2812_data_out <= line_nxt;
   end

endmodule

// File: tb/tb_ws2812_multi_out.sv
// Scoreboard bench for ws2812_multi_out: stimulus queues expected pulses/reads/done events, monitors check them.
module tb_ws2812_multi_out;

   localparam int NCH = 2, MAXL = 4, TB = 10, T0 = 3, T1 = 7, TR = 20;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        frame_rdy_in = 1'b0;
   logic [2:0]  led_num_in = '0;
   logic [1:0]  chan_en_in = '0;
   logic        rd_en_out;
   logic [1:0]  rd_addr_out;
   logic [47:0] rd_data_in = '0;
   logic        busy_out, done_out;
   logic [1:0]  ws2812_data_out;

   ws2812_multi_out #(.NUM_CH(NCH), .MAX_LEDS(MAXL), .T_BIT(TB), .T0H(T0), .T1H(T1), .T_RST(TR)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .frame_rdy_in    (frame_rdy_in),
      .led_num_in      (led_num_in),
      .chan_en_in      (chan_en_in),
      .rd_en_out       (rd_en_out),
      .rd_addr_out     (rd_addr_out),
      .rd_data_in      (rd_data_in),
      .busy_out        (busy_out),
      .done_out        (done_out),
      .ws2812_data_out (ws2812_data_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {int t; int w;} pulse_t;
   typedef struct {int t; logic busy;} done_t;

   logic [47:0] mem [4];
   pulse_t      pq [2][$];
   int          exp_addr [$];
   done_t       exp_done [$];
   int          cyc = 0, done_cnt = 0, n_tests = 0, n_fail = 0;
   logic        hi [2];
   int          rise [2];

   initial begin
      mem[0] = {24'h000000, 24'h800001};
      mem[1] = {24'h123456, 24'hA5F00F};
      mem[2] = {24'h0F0F0F, 24'hFFFFFF};
      mem[3] = {24'hC3C3C3, 24'h000000};
   end

   always @(posedge clk_in) begin
      cyc <= cyc + 1;
      if (rd_en_out) rd_data_in <= mem[rd_addr_out];
   end

   // Pulse monitor: each completed high pulse is matched against the next expected (rise time, width).
   always @(negedge clk_in) begin
      pulse_t e;
      int w;
      if (rst_in) begin
         hi[0] = 1'b0;
         hi[1] = 1'b0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (ws2812_data_out[c] && !hi[c]) begin
               hi[c] = 1'b1;
               rise[c] = cyc;
            end else if (!ws2812_data_out[c] && hi[c]) begin
               hi[c] = 1'b0;
               w = cyc - rise[c];
               n_tests++;
               if (pq[c].size() == 0) begin
                  n_fail++;
                  $display("FAIL pulse_ch%0d: got pulse at %0d width %0d, required none", c, rise[c], w);
               end else begin
                  e = pq[c].pop_front();
                  if (e.t != rise[c] || e.w != w) begin
                     n_fail++;
                     $display("FAIL pulse_ch%0d: got rise %0d width %0d, required rise %0d width %0d",
                              c, rise[c], w, e.t, e.w);
                  end
               end
            end
         end
      end
   end

   always @(negedge clk_in) begin
      int a;
      done_t d;
      if (!rst_in && rd_en_out) begin
         n_tests++;
         if (exp_addr.size() == 0) begin
            n_fail++;
            $display("FAIL rd_addr: got read of %0d, required none", rd_addr_out);
         end else begin
            a = exp_addr.pop_front();
            if (int'(rd_addr_out) != a) begin
               n_fail++;
               $display("FAIL rd_addr: got %0d, required %0d", rd_addr_out, a);
            end
         end
      end
      if (!rst_in && done_out) begin
         done_cnt++;
         n_tests++;
         if (exp_done.size() == 0) begin
            n_fail++;
            $display("FAIL done: got done_out at %0d, required none", cyc);
         end else begin
            d = exp_done.pop_front();
            if (d.t != cyc || d.busy != busy_out) begin
               n_fail++;
               $display("FAIL done: got at %0d busy %0b, required at %0d busy %0b", cyc, busy_out, d.t, d.busy);
            end
         end
      end
   end

   task automatic check(input string name, input int got, input int req);
      n_tests++;
      if (got != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   // Expected response of one frame whose frame_rdy_in is sampled at the edge where cyc becomes t0.
   task automatic expect_frame(input int n, input logic [1:0] en, input int t0, input logic last_busy);
      pulse_t p;
      done_t  d;
      for (int i = 0; i < n; i++) exp_addr.push_back(i);
      for (int c = 0; c < 2; c++)
         if (en[c])
            for (int i = 0; i < n; i++)
               for (int b = 23; b >= 0; b--) begin
                  p.t = t0 + 3 + (i*24 + 23 - b)*TB;
                  p.w = mem[i][c*24+b] ? T1 : T0;
                  pq[c].push_back(p);
               end
      d.t = (n == 0) ? t0 + TR : t0 + 3 + 24*TB*n + TR;
      d.busy = last_busy;
      exp_done.push_back(d);
   endtask

   task automatic issue(input int n_req, input logic [1:0] en, output int t0);
      @(negedge clk_in);
      led_num_in = n_req[2:0];
      chan_en_in = en;
      frame_rdy_in = 1'b1;
      t0 = cyc + 1;
      expect_frame((n_req > MAXL) ? MAXL : n_req, en, t0, 1'b0);
      @(negedge clk_in);
      frame_rdy_in = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_cnt < target && n < 3000) begin
         @(negedge clk_in);
         n++;
      end
      check("done_timeout", done_cnt, target);
      repeat (5) @(negedge clk_in);
   endtask

   initial begin
      int t0, base;
      done_t d;
      repeat (3) @(negedge clk_in);
      check("rst_data", ws2812_data_out, 0);
      check("rst_busy", busy_out, 0);
      check("rst_done", done_out, 0);
      check("rst_rd_en", rd_en_out, 0);
      rst_in = 1'b0;
      repeat (2) @(negedge clk_in);

      issue(1, 2'b11, t0);
      wait_done(1);

      issue(3, 2'b11, t0);
      wait_done(2);

      issue(1, 2'b10, t0);
      wait_done(3);

      // Pending: frame of 2 LEDs, three requests during SEND, re-sampled led_num of 1.
      issue(2, 2'b11, t0);
      exp_done[exp_done.size()-1].busy = 1'b1;
      expect_frame(1, 2'b11, t0 + 3 + 48*TB + TR + 1, 1'b0);
      led_num_in = 3'd1;
      for (int k = 1; k <= 3; k++) begin
         while (cyc < t0 + 50*k) @(negedge clk_in);
         frame_rdy_in = 1'b1;
         @(negedge clk_in);
         frame_rdy_in = 1'b0;
      end
      wait_done(5);
      repeat (100) @(negedge clk_in);
      check("pending_done_count", done_cnt, 5);

      issue(0, 2'b11, t0);
      wait_done(6);

      issue(7, 2'b11, t0);
      wait_done(7);

      // Reset during the prefetch cycle of LED 0, while both lines are high.
      issue(2, 2'b11, t0);
      while (cyc < t0 + 233) @(negedge clk_in);
      check("pre_rst_rd_en", rd_en_out, 1);
      check("pre_rst_data", ws2812_data_out, 3);
      #2 rst_in = 1'b1;
      #1;
      check("midrst_data", ws2812_data_out, 0);
      check("midrst_busy", busy_out, 0);
      check("midrst_rd_en", rd_en_out, 0);
      pq[0].delete();
      pq[1].delete();
      exp_addr.delete();
      exp_done.delete();
      base = done_cnt;
      repeat (2) @(negedge clk_in);
      #2 rst_in = 1'b0;
      repeat (300) @(negedge clk_in);
      check("midrst_no_done", done_cnt, base);

      check("left_pulses_ch0", pq[0].size(), 0);
      check("left_pulses_ch1", pq[1].size(), 0);
      check("left_reads", exp_addr.size(), 0);
      check("left_done", exp_done.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ws2812_multi_out.md
Name: ws2812_multi_out

Overview:
Parametrised N-channel WS2812 serializer. It is the successor to the fixed eight-instance per-layer output stage. On a frame trigger it fetches one pixel word per LED from an external frame memory; each word carries 24 bits for every channel. It then drives all channels' WS2812 lines in parallel with configurable bit timing, a runtime LED count and a runtime channel-enable mask, and finishes each frame with a latch (reset) gap.

Parameters:
NUM_CH, 8, number of parallel WS2812 outputs (1..32)
MAX_LEDS, 64, frame-memory depth in LEDs per channel
T_BIT, 125, clk_in cycles per bit period (1.25 us at 100 MHz)
T0H, 40, high time in cycles for a 0 bit
T1H, 80, high time in cycles for a 1 bit
T_RST, 30000, low latch gap in cycles after the last bit (300 us)

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous reset, active-high
frame_rdy_in  in  1  single-cycle pulse requesting a frame transmission
led_num_in  in  $clog2(MAX_LEDS+1)  LED count per channel; sampled at frame start
chan_en_in  in  NUM_CH  channel enable mask; sampled at frame start
rd_en_out  in/out: out  1  frame-memory read strobe
rd_addr_out  out  $clog2(MAX_LEDS)  LED index to read
rd_data_in  in  NUM_CH*24  pixel word; channel c occupies bits [24c+23:24c] in GRB order, MSB first; valid one cycle after rd_en_out
busy_out  out  1  high from frame acceptance until done_out
done_out  out  1  single-cycle pulse at the end of the latch gap
ws2812_data_out  out  NUM_CH  serial lines, registered

Behaviour:
- Reset (asynchronous, rst_in=1): state IDLE; all outputs 0; pending flag cleared. A reset asserted mid-frame drops all lines low immediately and abandons the frame with no done_out.
- Elaboration checks: T0H<T1H<T_BIT, T_RST>=T_BIT, MAX_LEDS>=1. Any violation is a $fatal.
- IDLE: on frame_rdy_in, latch led_num_in and chan_en_in, set busy_out.
  - If led_num==0, go to GAP.
  - Otherwise go to FETCH with rd_addr=0 and rd_en_out=1 for one cycle.
- FETCH: one wait cycle, then load rd_data_in into the shift register. Go to SEND with bit_cnt=23 and cyc_cnt=0. Latency from frame_rdy_in to the first rising edge on ws2812_data_out is 3 cycles.
- SEND, per bit:
  - Output for channel c is high while cyc_cnt < (bit ? T1H : T0H), low otherwise, ANDed with the latched chan_en[c].
  - cyc_cnt wraps at T_BIT-1; bit_cnt then decrements.
- Prefetch: at cyc_cnt==0 of bit 0 of LED k, if k+1<led_num, pulse rd_en_out with addr k+1. Capture rd_data_in into the next-pixel register one cycle later. At the bit-0 wrap, move the next-pixel register into the shift register with no idle cycles, so bit periods stay exactly T_BIT back-to-back.
- Last bit of LED led_num-1 completes: go to GAP with lines low for exactly T_RST cycles, then pulse done_out, clear busy_out and return to IDLE.
- A frame_rdy_in while busy sets the pending flag; further pulses are absorbed into the single flag. At GAP end, done_out pulses and, if pending is set, a new frame starts on the next cycle: parameters are re-sampled, the flag is cleared and busy_out stays high.
- frame_rdy_in in the same cycle as done_out with nothing pending is treated as pending and starts the next frame.
- led_num_in>MAX_LEDS is saturated to MAX_LEDS.
- Disabled channels hold 0 for the whole frame. Timing and memory reads are unaffected by the mask.

Decomposition:
- Shared package ws2812_pkg: state enum (IDLE, FETCH, SEND, GAP), PIXEL_W=24, and a helper that extracts channel c's slice from a pixel word.
- Sub-module ws2812_bit_timer: holds cyc_cnt/bit_cnt and emits bit_start, bit_end and the high-window compare. It is shared by all channels. The per-channel logic is a generate loop of shift-register MSB AND compare AND enable.

Test Plan:
All scenarios use NUM_CH=2, MAX_LEDS=4, T_BIT=10, T0H=3, T1H=7, T_RST=20.
- Reset: pulse rst_in mid-SEND -> ws2812_data_out=0, busy_out=0 and rd_en_out=0 in the same cycle; no done_out follows.
- Single LED: led_num=1, mem[0] ch0=0x800001, ch1=0x000000 -> ch0 bit23 high 7 cycles, bits 22..1 high 3 cycles, bit0 high 7 cycles; ch1 all 3-cycle highs; 240 cycles, then 20 low cycles, then done_out.
- Continuity: led_num=3 -> rd_addr sequence 0,1,2; 720 contiguous SEND cycles with rising edges exactly every 10 cycles; done_out at cycle 3+720+20.
- Mask: chan_en=2'b10 -> ch0 constant 0, ch1 normal; rd_en_out count unchanged.
- Pending: three frame_rdy_in pulses during SEND -> exactly one extra frame; busy_out stays high between frames; exactly two done_out pulses.
- Edge counts: led_num=0 -> no rd_en_out, 20-cycle gap, done_out. led_num=7 -> treated as 4 LEDs.
